// File: rtl/invaders_pkg.sv
// Shared constants and types for the space invaders datapath: coordinate and
// colour widths, palette entries, playfield bounds and the ship FSM encoding.
package invaders_pkg;

    localparam int INV_COORD_W  = 8;
    localparam int INV_COLOUR_W = 3;

    localparam logic [INV_COLOUR_W-1:0] INV_SHIP_COLOUR = 3'b111;
    localparam logic [INV_COLOUR_W-1:0] INV_BG_COLOUR   = 3'b000;

    localparam int INV_X_HOME = 155;
    localparam int INV_Y_MIN  = 0;
    localparam int INV_Y_MAX  = 116;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ERASE = 2'd2,
        ST_DRAW  = 2'd3
    } ship_state_e;

endpackage

// File: rtl/player_ship_ctrl_sprite_scanner.sv
// Rectangular sprite scanner: walks dx (inner) and dy (outer) over an
// SPR_W x SPR_H box and offers one pixel at a time on a valid/ready link.
// Base position and colour are latched on start so the offer stays stable
// while the consumer stalls. A start coinciding with the last transfer
// chains straight into the next pass without a bubble.
module sprite_scanner
    import invaders_pkg::*;
#(
    parameter int COORD_W  = INV_COORD_W,
    parameter int COLOUR_W = INV_COLOUR_W,
    parameter int SPR_W    = 2,
    parameter int SPR_H    = 4,
    parameter int X_RST    = INV_X_HOME,
    parameter int Y_RST    = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [COORD_W-1:0]  base_x,
    input  logic [COORD_W-1:0]  base_y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                plot_ready,
    output logic                plot_valid,
    output logic [COORD_W-1:0]  plot_x,
    output logic [COORD_W-1:0]  plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    output logic                done
);

    logic [COORD_W-1:0]  dx, dy;
    logic [COORD_W-1:0]  bx, by;
    logic [COLOUR_W-1:0] col;
    logic                last_px, xfer, last_dx;

    // Transfer qualification and end-of-pass detection.
    always_comb begin
        last_dx     = (dx == COORD_W'(SPR_W - 1));
        last_px     = last_dx && (dy == COORD_W'(SPR_H - 1));
        xfer        = plot_valid && plot_ready;
        done        = xfer && last_px;
        plot_x      = bx + dx;
        plot_y      = by + dy;
        plot_colour = col;
    end

    // Scan counters, latched base and offer-valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            plot_valid <= 1'b0;
            dx         <= '0;
            dy         <= '0;
            bx         <= COORD_W'(X_RST);
            by         <= COORD_W'(Y_RST);
            col        <= '0;
        end else if (xfer && !last_px) begin
            if (last_dx) begin
                dx <= '0;
                dy <= dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end else if (start && (!plot_valid || done)) begin
            plot_valid <= 1'b1;
            dx         <= '0;
            dy         <= '0;
            bx         <= base_x;
            by         <= base_y;
            col        <= colour;
        end else if (done) begin
            plot_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/player_ship_ctrl.sv
// Player ship controller: holds the ship row at a fixed column, applies
// clamped per-frame moves, streams erase/redraw pixels of the sprite to the
// plot arbiter and turns fire requests into rate-limited shot pulses.
module player_ship_ctrl
    import invaders_pkg::*;
#(
    parameter int COORD_W  = INV_COORD_W,
    parameter int X_HOME   = INV_X_HOME,
    parameter int Y_HOME   = 0,
    parameter int Y_MIN    = INV_Y_MIN,
    parameter int Y_MAX    = INV_Y_MAX,
    parameter int STEP     = 1,
    parameter int SPR_W    = 2,
    parameter int SPR_H    = 4,
    parameter int COOLDOWN = 30,
    parameter int COLOUR_W = INV_COLOUR_W,
    parameter logic [COLOUR_W-1:0] SHIP_COLOUR = COLOUR_W'(INV_SHIP_COLOUR),
    parameter logic [COLOUR_W-1:0] BG_COLOUR   = COLOUR_W'(INV_BG_COLOUR)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                move_inc,
    input  logic                move_dec,
    input  logic                fire,
    input  logic                plot_ready,
    output logic                plot_valid,
    output logic [COORD_W-1:0]  plot_x,
    output logic [COORD_W-1:0]  plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    output logic [COORD_W-1:0]  ship_y,
    output logic                busy,
    output logic                shot_pulse,
    output logic [COORD_W-1:0]  shot_y
);

    localparam int XW   = COORD_W + 1;
    localparam int CD_W = $clog2(COOLDOWN + 2);

    ship_state_e         state, state_nxt;
    logic [COORD_W-1:0]  old_y, cand_y, ship_y_nxt;
    logic [COORD_W-1:0]  base_y;
    logic [COLOUR_W-1:0] base_colour;
    logic                move_ok, start_q, start_nxt, scan_start, scan_done;
    logic [CD_W-1:0]     cooldown;

    // One extra bit of headroom so neither the increment nor the decrement
    // can wrap before the clamp is applied.
    function automatic logic [COORD_W-1:0] clamp_move(
        input logic [COORD_W-1:0] y,
        input logic               inc,
        input logic               dec
    );
        logic [XW-1:0] wide;
        wide = {1'b0, y};
        if (inc && !dec) begin
            wide = wide + XW'(STEP);
            if (wide > XW'(Y_MAX))
                wide = XW'(Y_MAX);
        end else if (dec && !inc) begin
            if (wide < XW'(Y_MIN + STEP))
                wide = XW'(Y_MIN);
            else
                wide = wide - XW'(STEP);
        end
        return wide[COORD_W-1:0];
    endfunction

    // Next-state, move commit and scanner start/base selection.
    always_comb begin
        state_nxt   = state;
        start_nxt   = 1'b0;
        move_ok     = 1'b0;
        cand_y      = clamp_move(ship_y, move_inc, move_dec);
        ship_y_nxt  = ship_y;
        case (state)
            ST_INIT: begin
                state_nxt = ST_DRAW;
                start_nxt = 1'b1;
            end
            ST_IDLE: begin
                if (frame_tick && (cand_y != ship_y)) begin
                    move_ok    = 1'b1;
                    ship_y_nxt = cand_y;
                    state_nxt  = ST_ERASE;
                    start_nxt  = 1'b1;
                end
            end
            ST_ERASE: if (scan_done) state_nxt = ST_DRAW;
            ST_DRAW:  if (scan_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase

        // The draw pass is launched on the same cycle the erase pass ends,
        // so the two passes run back to back.
        scan_start = start_q || ((state == ST_ERASE) && scan_done);
        if ((state == ST_ERASE) && !scan_done) begin
            base_y      = old_y;
            base_colour = BG_COLOUR;
        end else begin
            base_y      = ship_y;
            base_colour = SHIP_COLOUR;
        end
        busy = (state != ST_IDLE);
    end

    // FSM state, committed/previous ship row and the registered pass start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_INIT;
            start_q <= 1'b0;
            ship_y  <= COORD_W'(Y_HOME);
            old_y   <= COORD_W'(Y_HOME);
        end else begin
            state   <= state_nxt;
            start_q <= start_nxt;
            ship_y  <= ship_y_nxt;
            if (move_ok)
                old_y <= ship_y;
        end
    end

    // Fire cooldown: a launching tick reloads the counter instead of
    // decrementing it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cooldown   <= '0;
            shot_pulse <= 1'b0;
            shot_y     <= '0;
        end else begin
            shot_pulse <= 1'b0;
            if (frame_tick) begin
                if (fire && (cooldown == '0)) begin
                    shot_pulse <= 1'b1;
                    shot_y     <= ship_y_nxt + COORD_W'(SPR_H / 2);
                    cooldown   <= CD_W'(COOLDOWN);
                end else if (cooldown != '0) begin
                    cooldown <= cooldown - 1'b1;
                end
            end
        end
    end

    sprite_scanner #(
        .COORD_W  (COORD_W),
        .COLOUR_W (COLOUR_W),
        .SPR_W    (SPR_W),
        .SPR_H    (SPR_H),
        .X_RST    (X_HOME),
        .Y_RST    (Y_HOME)
    ) u_scanner (
        .clk         (clk),
        .reset       (reset),
        .start       (scan_start),
        .base_x      (COORD_W'(X_HOME)),
        .base_y      (base_y),
        .colour      (base_colour),
        .plot_ready  (plot_ready),
        .plot_valid  (plot_valid),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .done        (scan_done)
    );

endmodule

// File: tb/tb_player_ship_ctrl.sv
// Bench for player_ship_ctrl: directed moves, limit cases, stalled handshake,
// fire cooldown and mid-pass reset. Expected pixels go into a queue and a
// separate monitor pops and compares them on every accepted transfer.
module tb_player_ship_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       move_inc = 1'b0;
    logic       move_dec = 1'b0;
    logic       fire = 1'b0;
    logic       plot_ready = 1'b1;
    logic       plot_valid;
    logic [7:0] plot_x, plot_y;
    logic [2:0] plot_colour;
    logic [7:0] ship_y;
    logic       busy;
    logic       shot_pulse;
    logic [7:0] shot_y;

    int n_checks = 0;
    int n_pass   = 0;
    int xfer_cnt = 0;

    logic [18:0] exp_q[$];

    player_ship_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .move_inc    (move_inc),
        .move_dec    (move_dec),
        .fire        (fire),
        .plot_ready  (plot_ready),
        .plot_valid  (plot_valid),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .ship_y      (ship_y),
        .busy        (busy),
        .shot_pulse  (shot_pulse),
        .shot_y      (shot_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares every accepted pixel, checks stall stability and drops.
    initial begin
        logic        stalled;
        logic [18:0] held, act;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            act = {plot_x, plot_y, plot_colour};
            if (reset) begin
                stalled = 1'b0;
            end else if (plot_valid) begin
                if (stalled) check("stall_hold", act, held);
                if (plot_ready) begin
                    if (exp_q.size() == 0) check("unexpected_pixel", act, 32'hffff_ffff);
                    else check("pixel", act, exp_q.pop_front());
                    xfer_cnt++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = act;
                end
            end else begin
                if (stalled) check("valid_drop", 0, 1);
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pass(input int y, input logic [2:0] col);
        for (int dy = 0; dy < 4; dy++)
            for (int dx = 0; dx < 2; dx++)
                exp_q.push_back({8'(155 + dx), 8'(y + dy), col});
    endtask

    task automatic tick(input logic inc, input logic dec, input logic f);
        move_inc   = inc;
        move_dec   = dec;
        fire       = f;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        move_inc   = 1'b0;
        move_dec   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        for (k = 0; k < 400; k++) begin
            if (!busy && exp_q.size() == 0) break;
            cyc();
        end
        check(name, (k < 400), 1);
    endtask

    task automatic do_move(input logic inc, input logic dec, input int from_y, input int to_y);
        push_pass(from_y, 3'd0);
        push_pass(to_y, 3'd7);
        tick(inc, dec, 1'b0);
        check("move_ship_y", ship_y, to_y);
        check("move_valid_lat0", plot_valid, 0);
        cyc();
        check("move_valid_lat1", plot_valid, 1);
        wait_idle("move_done");
    endtask

    task automatic no_move(input logic inc, input logic dec, input int y);
        tick(inc, dec, 1'b0);
        check("nomove_busy", busy, 0);
        repeat (6) cyc();
        check("nomove_ship_y", ship_y, y);
        check("nomove_valid", plot_valid, 0);
    endtask

    initial begin
        int x0, npulse;
        logic exp_p;

        // Reset values
        repeat (2) cyc();
        check("rst_valid", plot_valid, 0);
        check("rst_x", plot_x, 155);
        check("rst_y", plot_y, 0);
        check("rst_colour", plot_colour, 0);
        check("rst_ship_y", ship_y, 0);
        check("rst_busy", busy, 1);
        check("rst_shot_pulse", shot_pulse, 0);
        check("rst_shot_y", shot_y, 0);

        // Initial draw at Y_HOME, first valid two cycles after release
        push_pass(0, 3'd7);
        reset = 1'b0;
        check("init_valid_c0", plot_valid, 0);
        cyc();
        check("init_valid_c1", plot_valid, 0);
        cyc();
        check("init_valid_c2", plot_valid, 1);
        wait_idle("init_done");
        check("init_busy", busy, 0);
        check("init_ship_y", ship_y, 0);

        // Ramp up to row 10, then the explicit 10 -> 11 move
        for (int y = 0; y < 10; y++) do_move(1'b1, 1'b0, y, y + 1);
        do_move(1'b1, 1'b0, 10, 11);
        check("move_10_11", ship_y, 11);

        // Stalled handshake with a discarded frame_tick mid-pass
        push_pass(11, 3'd0);
        push_pass(12, 3'd7);
        x0 = xfer_cnt;
        tick(1'b1, 1'b0, 1'b0);
        move_inc = 1'b1;
        for (int k = 0; k < 300; k++) begin
            plot_ready = ((k % 3) == 2);
            frame_tick = (k == 5);
            cyc();
            frame_tick = 1'b0;
            if (!busy) break;
        end
        plot_ready = 1'b1;
        move_inc   = 1'b0;
        repeat (3) cyc();
        check("stall_busy", busy, 0);
        check("stall_xfers", xfer_cnt - x0, 16);
        check("stall_ship_y", ship_y, 12);
        check("stall_queue", exp_q.size(), 0);

        // Ramp to the upper limit, then limit and both-asserted cases
        for (int y = 12; y < 116; y++) do_move(1'b1, 1'b0, y, y + 1);
        no_move(1'b1, 1'b0, 116);
        no_move(1'b1, 1'b1, 116);

        // Fire held for 70 ticks
        npulse = 0;
        for (int i = 1; i <= 70; i++) begin
            tick(1'b0, 1'b0, 1'b1);
            exp_p = (i == 1) || (i == 32) || (i == 63);
            check("shot_pulse", shot_pulse, exp_p);
            if (shot_pulse) begin
                npulse++;
                check("shot_y", shot_y, 118);
            end
            cyc();
            check("shot_pulse_width", shot_pulse, 0);
        end
        fire = 1'b0;
        check("shot_count", npulse, 3);

        // Reset asserted in the middle of an erase pass
        push_pass(116, 3'd0);
        tick(1'b0, 1'b1, 1'b0);
        check("mid_ship_y", ship_y, 115);
        repeat (4) cyc();
        check("mid_valid_pre", plot_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", plot_valid, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_ship_y", ship_y, 0);
        check("mid_rst_y", plot_y, 0);
        exp_q.delete();
        push_pass(0, 3'd7);
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        check("post_rst_valid_c1", plot_valid, 0);
        cyc();
        check("post_rst_valid_c2", plot_valid, 1);
        wait_idle("post_rst_done");
        check("post_rst_ship_y", ship_y, 0);

        // Lower limit
        no_move(1'b0, 1'b1, 0);

        check("final_queue", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/player_ship_ctrl.md
# player_ship_ctrl

Parametrised player-ship controller for the space invaders datapath. Holds the ship's vertical position at a fixed column and applies per-frame moves with clamping to the playfield. Streams erase and redraw pixels for the ship sprite to the VGA plot arbiter over a valid/ready handshake. Also rate-limits fire requests into single-cycle shot pulses.

## Interface
- COORD_W, 8: width of the x/y coordinates.
- X_HOME, 155: fixed ship column (left edge of the sprite).
- Y_HOME, 0: ship row after reset.
- Y_MIN, 0: lowest legal ship row.
- Y_MAX, 116: highest legal ship row. Constraint: Y_MAX+SPR_H-1 ≤ 2^COORD_W-1.
- STEP, 1: rows moved per accepted frame move.
- SPR_W, 2 / SPR_H, 4: sprite width and height in pixels.
- COOLDOWN, 30: frames blocked after a shot.
- COLOUR_W, 3 / SHIP_COLOUR, 3'b111 / BG_COLOUR, 3'b000: colour width and values.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- move_inc  in  1  level; request to increase y.
- move_dec  in  1  level; request to decrease y.
- fire  in  1  level; fire request.
- plot_ready  in  1  arbiter accepts the current pixel.
- plot_valid  out  1  pixel offer is valid.
- plot_x, plot_y  out  COORD_W  pixel coordinate.
- plot_colour  out  COLOUR_W  pixel colour.
- ship_y  out  COORD_W  committed ship row.
- busy  out  1  a draw or erase pass is in progress.
- shot_pulse  out  1  one-cycle shot launch.
- shot_y  out  COORD_W  launch row, equal to ship_y + SPR_H/2 at the pulse.

## Operation
- FSM states: INIT, IDLE, ERASE, DRAW.
  - reset → INIT.
  - INIT → DRAW after one cycle, which draws the ship at Y_HOME.
  - IDLE → ERASE when a frame_tick produces a changed position.
  - ERASE → DRAW after the last erase pixel is accepted.
  - DRAW → IDLE after the last draw pixel is accepted.
- Move evaluation happens only on a frame_tick while in IDLE:
  - inc only: candidate = ship_y+STEP, clamped to Y_MAX.
  - dec only: candidate = ship_y−STEP, floored at Y_MIN.
  - both asserted or neither asserted: no move.
  - Arithmetic is COORD_W+1 bits wide, so the result never wraps.
- If candidate equals ship_y (for example, already at a limit): stay in IDLE with no pixel traffic.
- Otherwise: latch old_y = ship_y, commit ship_y = candidate, then go to ERASE.
- A frame_tick arriving in INIT, ERASE or DRAW is discarded. No queueing.
- Pixel scan uses counters dx (0..SPR_W−1, inner) and dy (0..SPR_H−1, outer). Each pass emits SPR_W*SPR_H pixels.
  - ERASE: plot_x = X_HOME+dx, plot_y = old_y+dy, colour BG_COLOUR.
  - DRAW: plot_x = X_HOME+dx, plot_y = ship_y+dy, colour SHIP_COLOUR.
- Handshake rules:
  - A pixel transfers when plot_valid && plot_ready.
  - While plot_valid && !plot_ready, plot_x, plot_y and plot_colour are held stable.
  - plot_valid never drops without a transfer, except on reset.
- Fire logic is independent of the FSM state:
  - cooldown counter decrements by 1 per frame_tick while nonzero.
  - On a frame_tick with fire=1 and cooldown=0: shot_pulse=1 for one cycle, shot_y registered, cooldown loaded with COOLDOWN.
  - That same tick does not also decrement the counter.
- busy = (state ≠ IDLE).

## Timing
- Reset values:
  - plot_valid 0, plot_x X_HOME, plot_y Y_HOME, plot_colour 0.
  - ship_y Y_HOME, busy 1, shot_pulse 0, shot_y 0, cooldown 0.
- Reset asserted mid-pass: all outputs take their reset values immediately (asynchronously). The in-flight pixel is abandoned.
- First plot_valid=1 occurs 2 cycles after reset deassertion: INIT, then DRAW.
- frame_tick in IDLE with a move: ship_y updates on the next edge. plot_valid rises 1 cycle later, with the first ERASE pixel.
- With plot_ready held at 1, each pixel takes one cycle. A full move takes 2*SPR_W*SPR_H cycles from first valid to IDLE; busy falls the cycle after the last DRAW transfer.
- shot_pulse is asserted the cycle after the qualifying frame_tick.

## Structure
- A shared package `invaders_pkg` holds COORD_W, COLOUR_W, the colour constants and the playfield bounds. The game controller and alien blocks use the same package.
- One natural sub-module: `sprite_scanner`. It contains the dx/dy counters and the handshake, with inputs for base x/y, colour and a start pulse, and a done pulse as output.
- The FSM, clamp logic and fire cooldown stay at the top level.

## Test plan
- Reset release, plot_ready=1: 8 DRAW pixels at (155..156, 0..3) in colour 7, then busy=0 and ship_y=0.
- ship_y=10, move_inc and one frame_tick: 8 erase pixels at rows 10..13 in colour 0, then 8 draw pixels at rows 11..14 in colour 7; ship_y=11.
- ship_y=116 with move_inc, and separately ship_y=0 with move_dec: no plot_valid, ship_y unchanged. Both move_inc and move_dec asserted: no move.
- plot_ready toggling 1-of-3 cycles: coordinates stay stable during stalls, exactly 16 transfers occur, no drops or duplicates. A frame_tick during the stall is ignored.
- fire held high over 70 frame_ticks with COOLDOWN=30: exactly three shot_pulses, at ticks 1, 32 and 63. Each pulse has shot_y = ship_y+2.
- reset asserted mid-ERASE: plot_valid drops immediately. After release, a fresh DRAW happens at Y_HOME.
